// File: rtl/replica_pkg.sv
// Shared types for the 2-opt / or-opt distance sequencing path.
package replica_pkg;

  // Number of tour positions in the default configuration.
  localparam int city_num = 30;

  // Longest distance-command sequence any opt can produce.
  localparam int max_seq_len = 6;

  typedef enum logic [1:0] {
    TWO = 2'd0,
    OR0 = 2'd1,
    OR1 = 2'd2,
    THR = 2'd3
  } opt_command_t;

  typedef struct packed {
    opt_command_t command;
    logic [6:0]   k;
    logic [6:0]   l;
  } opt_t;

  typedef enum logic [2:0] {
    KN = 3'd0,
    LN = 3'd1,
    KP = 3'd2,
    LP = 3'd3,
    KM = 3'd4,
    LM = 3'd5
  } distance_select_t;

  typedef enum logic [1:0] {
    DNOP = 2'd0,
    ZERO = 2'd1,
    PLS  = 2'd2,
    MNS  = 2'd3
  } distance_op_t;

  typedef struct packed {
    distance_select_t select;
    distance_op_t     op;
  } distance_command_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Index of the final command for a given opt type.
  function automatic logic [2:0] seq_last(opt_command_t c);
    return (c == TWO) ? 3'd3 : 3'(max_seq_len - 1);
  endfunction

  // Command issued at a given step of the sequence for an opt type.
  function automatic distance_command_t seq_cmd(opt_command_t c, logic [2:0] step);
    distance_command_t r;
    r = '{select: KN, op: DNOP};
    if (c == TWO) begin
      case (step)
        3'd0:    r = '{select: KN, op: ZERO};
        3'd1:    r = '{select: LN, op: PLS};
        3'd2:    r = '{select: KP, op: MNS};
        3'd3:    r = '{select: LP, op: MNS};
        default: r = '{select: KN, op: DNOP};
      endcase
    end else begin
      case (step)
        3'd0:    r = '{select: LM, op: ZERO};
        3'd1:    r = '{select: KN, op: PLS};
        3'd2:    r = '{select: LN, op: PLS};
        3'd3:    r = '{select: KM, op: MNS};
        3'd4:    r = '{select: KP, op: MNS};
        3'd5:    r = '{select: LP, op: MNS};
        default: r = '{select: KN, op: DNOP};
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/opt_pos_wrap.sv
// Neighbour of a tour position, wrapping around the ring of CITY_NUM positions.
import replica_pkg::*;

module opt_pos_wrap #(
  parameter int CITY_NUM = city_num
) (
  input  logic [6:0] pos,
  input  logic       dec,
  output logic [6:0] pos_out
);

  // Step one position forward or backward with wrap at both ends.
  always_comb begin
    if (dec) begin
      pos_out = (pos == 7'd0) ? 7'(CITY_NUM - 1) : pos - 7'd1;
    end else begin
      pos_out = (pos == 7'(CITY_NUM - 1)) ? 7'd0 : pos + 7'd1;
    end
  end

endmodule

// File: rtl/opt_dist_seq.sv
// Turns one accepted opt into its sequence of distance-unit commands.
import replica_pkg::*;

module opt_dist_seq #(
  parameter int CITY_NUM = city_num
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              opt_valid,
  output logic              opt_ready,
  input  opt_t              opt_in,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output distance_command_t cmd_out,
  output logic [6:0]        pos_a,
  output logic [6:0]        pos_b,
  output logic              done,
  output logic              err
);

  seq_state_t state_reg, state_next;
  logic [2:0] step_reg, step_next;
  opt_t       opt_reg, opt_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;
  logic       illegal;

  // Neighbours of the captured K and L: [0]=K+1, [1]=L+1, [2]=K-1.
  logic [6:0] wrap_out [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_wrap
    opt_pos_wrap #(.CITY_NUM(CITY_NUM)) u_wrap (
      .pos     ((gi == 1) ? opt_reg.l : opt_reg.k),
      .dec     (gi == 2),
      .pos_out (wrap_out[gi])
    );
  end

  // Out-of-range positions or an ordering the opt type cannot use.
  assign illegal = (opt_in.k >= 7'(CITY_NUM)) || (opt_in.l >= 7'(CITY_NUM)) ||
                   (((opt_in.command == TWO) || (opt_in.command == OR0)) &&
                    (opt_in.k >= opt_in.l)) ||
                   ((opt_in.command == OR1) &&
                    ({1'b0, opt_in.k} <= ({1'b0, opt_in.l} + 8'd1)));

  // State, step counter, captured opt and completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      step_reg  <= 3'd0;
      opt_reg   <= '{command: TWO, k: 7'd0, l: 7'd0};
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      opt_reg   <= opt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Next-state, handshakes and the command for the current step.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    opt_next   = opt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    opt_ready  = 1'b0;
    cmd_valid  = 1'b0;
    cmd_out    = '{select: KN, op: DNOP};
    case (state_reg)
      IDLE: begin
        opt_ready = 1'b1;
        if (opt_valid) begin
          opt_next = opt_in;
          if (illegal) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else if (opt_in.command == THR) begin
            done_next = 1'b1;
          end else begin
            step_next  = 3'd0;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        cmd_valid = 1'b1;
        cmd_out   = seq_cmd(opt_reg.command, step_reg);
        if (cmd_ready) begin
          if (step_reg == seq_last(opt_reg.command)) begin
            step_next  = 3'd0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            step_next = step_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Position pair named by the selected distance.
  always_comb begin
    pos_a = opt_reg.k;
    pos_b = opt_reg.l;
    case (cmd_out.select)
      KN: begin pos_a = opt_reg.k;   pos_b = opt_reg.l;   end
      LN: begin pos_a = wrap_out[0]; pos_b = wrap_out[1]; end
      KP: begin pos_a = opt_reg.k;   pos_b = wrap_out[0]; end
      LP: begin pos_a = opt_reg.l;   pos_b = wrap_out[1]; end
      KM: begin pos_a = wrap_out[2]; pos_b = opt_reg.k;   end
      LM: begin pos_a = wrap_out[2]; pos_b = wrap_out[0]; end
      default: begin pos_a = opt_reg.k; pos_b = opt_reg.l; end
    endcase
  end

  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_opt_dist_seq.sv
// Scoreboard bench for opt_dist_seq: expected commands and done/err are queued at stimulus time.
module tb_opt_dist_seq;
  import replica_pkg::*;

  localparam int CN = 30;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              opt_valid = 1'b0;
  logic              opt_ready;
  opt_t              opt_in = '{command: TWO, k: 7'd0, l: 7'd0};
  logic              cmd_valid;
  logic              cmd_ready = 1'b1;
  distance_command_t cmd_out;
  logic [6:0]        pos_a, pos_b;
  logic              done, err;

  opt_dist_seq #(.CITY_NUM(CN)) dut (
    .clk(clk), .reset(reset), .opt_valid(opt_valid), .opt_ready(opt_ready),
    .opt_in(opt_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_out(cmd_out),
    .pos_a(pos_a), .pos_b(pos_b), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    distance_command_t cmd;
    logic [6:0]        a;
    logic [6:0]        b;
  } exp_cmd_t;

  exp_cmd_t exp_q[$];
  logic     exp_done_q[$];
  int       compared = 0;
  int       mismatched = 0;
  int       ncmd = 0;

  distance_select_t two_sel [4] = '{KN, LN, KP, LP};
  distance_op_t     two_op  [4] = '{ZERO, PLS, MNS, MNS};
  distance_select_t or_sel  [6] = '{LM, KN, LN, KM, KP, LP};
  distance_op_t     or_op   [6] = '{ZERO, PLS, PLS, MNS, MNS, MNS};

  function automatic logic [6:0] m_inc(logic [6:0] p);
    return (p == 7'(CN - 1)) ? 7'd0 : p + 7'd1;
  endfunction

  function automatic logic [6:0] m_dec(logic [6:0] p);
    return (p == 7'd0) ? 7'(CN - 1) : p - 7'd1;
  endfunction

  function automatic exp_cmd_t mk(distance_select_t s, distance_op_t o, logic [6:0] k, logic [6:0] l);
    exp_cmd_t e;
    e.cmd.select = s;
    e.cmd.op     = o;
    case (s)
      KN:      begin e.a = k;        e.b = l;        end
      LN:      begin e.a = m_inc(k); e.b = m_inc(l); end
      KP:      begin e.a = k;        e.b = m_inc(k); end
      LP:      begin e.a = l;        e.b = m_inc(l); end
      KM:      begin e.a = m_dec(k); e.b = k;        end
      default: begin e.a = m_dec(k); e.b = m_inc(k); end
    endcase
    return e;
  endfunction

  // Monitor: pop expected commands on each handshake, expected err on each done.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        ncmd++;
        $display("cmd %0d: sel=%0d op=%0d a=%0d b=%0d", ncmd, cmd_out.select, cmd_out.op, pos_a, pos_b);
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_cmd: got sel=%0d op=%0d a=%0d b=%0d, expected none",
                   cmd_out.select, cmd_out.op, pos_a, pos_b);
        end else begin
          exp_cmd_t e;
          e = exp_q.pop_front();
          if ({cmd_out, pos_a, pos_b} !== e) begin
            mismatched++;
            $display("FAIL cmd: got sel=%0d op=%0d a=%0d b=%0d, expected sel=%0d op=%0d a=%0d b=%0d",
                     cmd_out.select, cmd_out.op, pos_a, pos_b, e.cmd.select, e.cmd.op, e.a, e.b);
          end
        end
      end
      if (!cmd_valid) begin
        compared++;
        if (cmd_out !== '{select: KN, op: DNOP}) begin
          mismatched++;
          $display("FAIL idle_cmd: got sel=%0d op=%0d, expected KN/DNOP", cmd_out.select, cmd_out.op);
        end
      end
      if (done) begin
        $display("done err=%0d", err);
        compared++;
        if (exp_done_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_done: got done=1 err=%0d, expected no done", err);
        end else begin
          logic ee;
          ee = exp_done_q.pop_front();
          if (err !== ee) begin
            mismatched++;
            $display("FAIL err: got %0d, expected %0d", err, ee);
          end
        end
      end
    end
  end

  // Drive one opt, queue its expectations and follow it to done.
  task automatic send_opt(opt_command_t c, int k, int l, int stall_step, int stall_cycles);
    bit illegal;
    int len, n, issued, stalled, exp_lat;
    bit done_seen;
    illegal = (k >= CN) || (l >= CN) || (((c == TWO) || (c == OR0)) && (k >= l)) ||
              ((c == OR1) && (k <= l + 1));
    len = (illegal || (c == THR)) ? 0 : ((c == TWO) ? 4 : 6);
    for (int i = 0; i < len; i++) begin
      if (c == TWO) exp_q.push_back(mk(two_sel[i], two_op[i], 7'(k), 7'(l)));
      else          exp_q.push_back(mk(or_sel[i], or_op[i], 7'(k), 7'(l)));
    end
    exp_done_q.push_back(illegal);
    $display("opt cmd=%0d k=%0d l=%0d expect_len=%0d err=%0d", c, k, l, len, illegal);

    opt_in    = '{command: c, k: 7'(k), l: 7'(l)};
    opt_valid = 1'b1;
    @(negedge clk);
    compared++;
    if (opt_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL opt_ready_idle: got %0d, expected 1", opt_ready);
    end
    @(posedge clk); #1;
    opt_valid = 1'b0;

    n = 0; issued = 0; stalled = 0; done_seen = 0;
    while (!done_seen && n < 40) begin
      cmd_ready = !((issued == stall_step) && (stalled < stall_cycles));
      @(negedge clk);
      n++;
      if (n == 1) begin
        compared++;
        if (cmd_valid !== (len != 0)) begin
          mismatched++;
          $display("FAIL first_valid: got %0d, expected %0d", cmd_valid, (len != 0));
        end
      end
      if (cmd_valid && !cmd_ready) begin
        stalled++;
        compared++;
        if (exp_q.size() == 0 || {cmd_out, pos_a, pos_b} !== exp_q[0]) begin
          mismatched++;
          $display("FAIL hold: got sel=%0d op=%0d a=%0d b=%0d under backpressure",
                   cmd_out.select, cmd_out.op, pos_a, pos_b);
        end
      end
      if (cmd_valid && cmd_ready) issued++;
      if (done) begin
        done_seen = 1;
        compared++;
        if (opt_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL ready_on_done: got %0d, expected 1", opt_ready);
        end
      end
      @(posedge clk); #1;
    end
    cmd_ready = 1'b1;

    exp_lat = (len == 0) ? 1 : len + 1 + stall_cycles;
    compared++;
    if (!done_seen || n != exp_lat) begin
      mismatched++;
      $display("FAIL done_latency: got %0d cycles (seen=%0d), expected %0d", n, done_seen, exp_lat);
    end
    compared++;
    if (issued != len || exp_q.size() != 0 || exp_done_q.size() != 0) begin
      mismatched++;
      $display("FAIL cmd_count: got %0d issued, %0d/%0d left, expected %0d issued",
               issued, exp_q.size(), exp_done_q.size(), len);
      exp_q.delete();
      exp_done_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({opt_ready, cmd_valid, done, err, pos_a, pos_b} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0}) begin
      mismatched++;
      $display("FAIL reset_state: got ready=%0d valid=%0d done=%0d err=%0d a=%0d b=%0d, expected 1 0 0 0 0 0",
               opt_ready, cmd_valid, done, err, pos_a, pos_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_two();
    send_opt(TWO, 3, 10, -1, 0);
    send_opt(TWO, 0, 29, -1, 0);
  endtask

  task automatic test_or_wrap();
    send_opt(OR0, 0, 27, -1, 0);
    send_opt(OR0, 5, 29, -1, 0);
    send_opt(OR1, 20, 5, -1, 0);
  endtask

  task automatic test_illegal();
    send_opt(TWO, 8, 8, -1, 0);
    send_opt(OR1, 0, 27, -1, 0);
    send_opt(OR0, 9, 3, -1, 0);
    send_opt(TWO, 2, 30, -1, 0);
    send_opt(THR, 1, 2, -1, 0);
  endtask

  task automatic test_backpressure();
    send_opt(TWO, 1, 5, 1, 3);
  endtask

  task automatic test_reset_abort();
    int hs;
    exp_q.push_back(mk(or_sel[0], or_op[0], 7'd4, 7'd12));
    exp_q.push_back(mk(or_sel[1], or_op[1], 7'd4, 7'd12));
    opt_in    = '{command: OR0, k: 7'd4, l: 7'd12};
    opt_valid = 1'b1;
    @(posedge clk); #1;
    opt_valid = 1'b0;
    hs = 0;
    for (int i = 0; i < 10 && hs < 2; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) hs++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({cmd_valid, opt_ready, done} !== 3'b010 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL abort: got valid=%0d ready=%0d done=%0d left=%0d, expected 0 1 0 0",
               cmd_valid, opt_ready, done, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    send_opt(OR0, 6, 20, -1, 0);
  endtask

  task automatic test_back_to_back();
    send_opt(TWO, 10, 11, -1, 0);
    send_opt(OR1, 29, 0, -1, 0);
    send_opt(TWO, 28, 29, -1, 0);
  endtask

  initial begin
    test_reset();
    test_two();
    test_or_wrap();
    test_illegal();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
